pll_supervisor: RTL

Reset and lock supervisor for the iCE40 PLL that generates the 201 MHz pulse-engine clock from the 12 MHz reference. It runs on the 12 MHz reference clock and drives the PLL's active-low reset. It qualifies the PLL lock signal, retries on lock timeout, and releases a clean active-high reset to the downstream pulse logic only after lock has been stable for a programmable time.

---
 rtl/pll_supervisor.sv | 126 ++++++++++++
 1 files changed

// File: rtl/pll_supervisor.sv
// Lock supervisor for the pulse-engine PLL: sequences the PLL reset, qualifies lock, retries on timeout.
// Optional macro PLL_SUPERVISOR_RELOCK_RESET_EN: loss of lock in RUN re-resets the PLL instead of waiting for relock.
module pll_supervisor #(
    parameter int RST_CYCLES     = 16,
    parameter int LOCK_CYCLES    = 1024,
    parameter int TIMEOUT_CYCLES = 65536,
    parameter int MAX_RETRIES    = 7
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       pll_lock,
    output logic       pll_resetb,
    output logic       sys_rst,
    output logic       ready,
    output logic       fault,
    output logic [2:0] retries
);

    localparam int MAX_RL  = (RST_CYCLES > LOCK_CYCLES) ? RST_CYCLES : LOCK_CYCLES;
    localparam int MAX_ALL = (MAX_RL > TIMEOUT_CYCLES) ? MAX_RL : TIMEOUT_CYCLES;
    localparam int CNT_MAX = MAX_ALL - 1;
    localparam int CW      = (CNT_MAX < 2) ? 1 : $clog2(CNT_MAX + 1);

    typedef enum logic [2:0] {
        HOLD      = 3'd0,
        WAIT_LOCK = 3'd1,
        SETTLE    = 3'd2,
        RUN       = 3'd3,
        FAULT     = 3'd4
    } state_t;

`ifdef PLL_SUPERVISOR_RELOCK_RESET_EN
    localparam state_t RUN_EXIT = HOLD;
`else
    localparam state_t RUN_EXIT = WAIT_LOCK;
`endif

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    retries_q, retries_d;
    logic          sync1_q, lock_s_q;
    logic          pll_resetb_q, pll_resetb_d;
    logic          sys_rst_q, sys_rst_d;
    logic          ready_q, ready_d;
    logic          fault_q, fault_d;

    always_comb begin
        state_d   = state_q;
        retries_d = retries_q;
        case (state_q)
            HOLD: begin
                if (cnt_q == CW'(RST_CYCLES - 1)) state_d = WAIT_LOCK;
            end
            WAIT_LOCK: begin
                // Lock takes priority over a coincident timeout.
                if (lock_s_q) begin
                    state_d = SETTLE;
                end else if (cnt_q == CW'(TIMEOUT_CYCLES - 1)) begin
                    if (retries_q == 3'(MAX_RETRIES)) begin
                        state_d = FAULT;
                    end else begin
                        state_d   = HOLD;
                        retries_d = retries_q + 3'd1;
                    end
                end
            end
            SETTLE: begin
                if (!lock_s_q) begin
                    state_d = WAIT_LOCK;
                end else if (cnt_q == CW'(LOCK_CYCLES - 1)) begin
                    state_d   = RUN;
                    retries_d = 3'd0;
                end
            end
            RUN: begin
                if (!lock_s_q) state_d = RUN_EXIT;
            end
            FAULT: state_d = FAULT;
            default: state_d = HOLD;
        endcase

        // Counter restarts on every state change and saturates rather than wrapping.
        if (state_d != state_q)
            cnt_d = '0;
        else if (cnt_q == CW'(CNT_MAX))
            cnt_d = cnt_q;
        else
            cnt_d = cnt_q + 1'b1;

        pll_resetb_d = !((state_d == HOLD) || (state_d == FAULT));
        sys_rst_d    = (state_d != RUN);
        ready_d      = (state_d == RUN);
        fault_d      = (state_d == FAULT);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_q      <= 1'b0;
            lock_s_q     <= 1'b0;
            state_q      <= HOLD;
            cnt_q        <= '0;
            retries_q    <= 3'd0;
            pll_resetb_q <= 1'b0;
            sys_rst_q    <= 1'b1;
            ready_q      <= 1'b0;
            fault_q      <= 1'b0;
        end else begin
            sync1_q      <= pll_lock;
            lock_s_q     <= sync1_q;
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            retries_q    <= retries_d;
            pll_resetb_q <= pll_resetb_d;
            sys_rst_q    <= sys_rst_d;
            ready_q      <= ready_d;
            fault_q      <= fault_d;
        end
    end

    assign pll_resetb = pll_resetb_q;
    assign sys_rst    = sys_rst_q;
    assign ready      = ready_q;
    assign fault      = fault_q;
    assign retries    = retries_q;

endmodule
